// File: rtl/icache_fill_server.sv
// icache_fill_server
// Memory-side responder for instruction-cache line misses. Miss requests
// (at most one outstanding per thread) are queued in arrival order and
// served one at a time on the main-memory read port. Each filled line is
// returned tagged with its requesting thread. Requests at or above
// ADDR_LIMIT are answered with a bus error and never reach memory.
//
// Ports:
//   clock, reset          system clock, asynchronous active-high reset
//   req_valid_miss        miss request strobe (one cycle per request)
//   req_addr_miss         miss physical address
//   req_thread_id_miss    requesting thread
//   mem_req_valid/addr    line-aligned read request to memory
//   mem_req_ready         memory accepts the request this cycle
//   mem_rsp_valid/data    one-cycle read data return
//   rsp_valid_miss        one-cycle fill response strobe
//   rsp_thread_id         thread the response belongs to
//   rsp_data_miss         filled line (zero on bus error)
//   rsp_bus_error         response carries a bus error
//   pending_thr           per-thread outstanding-request flags
//   err_dup               sticky duplicate-request error
module icache_fill_server #(
  parameter int                    NUM_THREADS      = 4,
  parameter int                    THR_ID_WIDTH     = 2,
  parameter int                    ADDR_WIDTH       = 20,
  parameter int                    LINE_WIDTH       = 128,
  parameter int                    LINE_OFFSET_BITS = 4,
  parameter logic [ADDR_WIDTH-1:0] ADDR_LIMIT       = 20'h80000
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    req_valid_miss,
  input  logic [ADDR_WIDTH-1:0]   req_addr_miss,
  input  logic [THR_ID_WIDTH-1:0] req_thread_id_miss,
  output logic                    mem_req_valid,
  output logic [ADDR_WIDTH-1:0]   mem_req_addr,
  input  logic                    mem_req_ready,
  input  logic                    mem_rsp_valid,
  input  logic [LINE_WIDTH-1:0]   mem_rsp_data,
  output logic                    rsp_valid_miss,
  output logic [THR_ID_WIDTH-1:0] rsp_thread_id,
  output logic [LINE_WIDTH-1:0]   rsp_data_miss,
  output logic                    rsp_bus_error,
  output logic [NUM_THREADS-1:0]  pending_thr,
  output logic                    err_dup
);

  localparam int CNT_W = THR_ID_WIDTH + 1;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t state, state_nxt;

  // Queue storage and bookkeeping
  logic [THR_ID_WIDTH-1:0] q_thr  [NUM_THREADS];
  logic [ADDR_WIDTH-1:0]   q_addr [NUM_THREADS];
  logic                    q_bad  [NUM_THREADS];
  logic [THR_ID_WIDTH-1:0] wr_ptr, rd_ptr;
  logic [CNT_W-1:0]        count;

  logic                    head_valid;
  logic [THR_ID_WIDTH-1:0] head_thr;
  logic [ADDR_WIDTH-1:0]   head_addr;
  logic                    head_bad;
  logic                    push, dup, pop;
  logic [NUM_THREADS-1:0]  pend_nxt;

  assign head_valid = (count != '0);
  assign head_thr   = q_thr[rd_ptr];
  assign head_addr  = q_addr[rd_ptr];
  assign head_bad   = q_bad[rd_ptr];

  // A thread already pending is dropped, so the queue can never overflow.
  assign push = req_valid_miss && !pending_thr[req_thread_id_miss];
  assign dup  = req_valid_miss &&  pending_thr[req_thread_id_miss];
  assign pop  = (state == RESP);

  // NOTE: queue storage has no reset; only the pointers and count decide
  // which entries are live, so stale contents after reset are harmless.
  always_ff @(posedge clock) begin
    if (push) begin
      q_thr[wr_ptr]  <= req_thread_id_miss;
      q_addr[wr_ptr] <= {req_addr_miss[ADDR_WIDTH-1:LINE_OFFSET_BITS],
                         {LINE_OFFSET_BITS{1'b0}}};
      q_bad[wr_ptr]  <= (req_addr_miss >= ADDR_LIMIT);
    end
  end

  // NOTE: every sequential assignment is non-blocking so all registers see
  // the pre-edge values of one another regardless of statement order.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + THR_ID_WIDTH'(1);
      if (pop)  rd_ptr <= rd_ptr + THR_ID_WIDTH'(1);
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Pop clears the head thread's flag; push sets the new thread's flag.
  // They never collide: a same-cycle re-request of the head thread still
  // sees its flag set and is treated as a duplicate.
  // NOTE: each always_comb variable gets a default first so no path leaves
  // it unassigned, which would otherwise infer a latch.
  always_comb begin
    pend_nxt = pending_thr;
    if (pop)  pend_nxt[head_thr]           = 1'b0;
    if (push) pend_nxt[req_thread_id_miss] = 1'b1;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      pending_thr <= '0;
      err_dup     <= 1'b0;
    end else begin
      pending_thr <= pend_nxt;
      if (dup) err_dup <= 1'b1;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (head_valid) state_nxt = head_bad ? RESP : ISSUE;
      ISSUE:   if (mem_req_ready) state_nxt = WAIT;
      WAIT:    if (mem_rsp_valid) state_nxt = RESP;
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Response fields are staged while the head is selected in IDLE, so
  // they are already registered by the time RESP drives the strobe. The
  // head does not move until RESP, so these stay valid through the read.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      mem_req_addr  <= '0;
      rsp_thread_id <= '0;
      rsp_data_miss <= '0;
      rsp_bus_error <= 1'b0;
    end else begin
      if (state == IDLE && head_valid) begin
        rsp_thread_id <= head_thr;
        rsp_bus_error <= head_bad;
        rsp_data_miss <= '0;
        if (!head_bad) mem_req_addr <= head_addr;
      end
      if (state == WAIT && mem_rsp_valid) rsp_data_miss <= mem_rsp_data;
    end
  end

  assign mem_req_valid  = (state == ISSUE);
  assign rsp_valid_miss = (state == RESP);

endmodule

// File: tb/tb_icache_fill_server.sv
// Self-checking bench for icache_fill_server. A transaction-level model
// (queue of accepted requests, per-thread pending bits, sticky dup flag)
// predicts what the DUT must present; a memory agent answers reads with
// random handshake and latency; directed sequences pin exact latencies.
module tb_icache_fill_server;

  logic         clock;
  logic         reset;
  logic         req_valid_miss;
  logic [19:0]  req_addr_miss;
  logic [1:0]   req_thread_id_miss;
  logic         mem_req_valid;
  logic [19:0]  mem_req_addr;
  logic         mem_req_ready;
  logic         mem_rsp_valid;
  logic [127:0] mem_rsp_data;
  logic         rsp_valid_miss;
  logic [1:0]   rsp_thread_id;
  logic [127:0] rsp_data_miss;
  logic         rsp_bus_error;
  logic [3:0]   pending_thr;
  logic         err_dup;

  icache_fill_server dut (
    .clock              (clock),
    .reset              (reset),
    .req_valid_miss     (req_valid_miss),
    .req_addr_miss      (req_addr_miss),
    .req_thread_id_miss (req_thread_id_miss),
    .mem_req_valid      (mem_req_valid),
    .mem_req_addr       (mem_req_addr),
    .mem_req_ready      (mem_req_ready),
    .mem_rsp_valid      (mem_rsp_valid),
    .mem_rsp_data       (mem_rsp_data),
    .rsp_valid_miss     (rsp_valid_miss),
    .rsp_thread_id      (rsp_thread_id),
    .rsp_data_miss      (rsp_data_miss),
    .rsp_bus_error      (rsp_bus_error),
    .pending_thr        (pending_thr),
    .err_dup            (err_dup)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [127:0] act,
                       input logic [127:0] exp);
    n_checks++;
    if (act !== exp)
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    else
      n_pass++;
  endtask

  // ---------------- memory agent ----------------
  int           ready_mode = 0;   // 0 random, 1 always ready, 2 never ready
  int           lat_lo = 0, lat_hi = 3;
  bit           spur_en = 0, spur_req = 0, fixed_en = 0;
  logic [127:0] fixed_data = '0;
  bit           outstanding = 0;
  int           lat_cnt = 0;
  bit           rd_fire = 0;
  logic [127:0] rd_data = '0;
  int           n_reads = 0;

  // Runs 2 time units after the edge so stimulus written at +1 is seen.
  always @(posedge clock) begin
    #2;
    rd_fire = 0;
    if (reset) begin
      outstanding   = 0;
      mem_req_ready = 0;
      mem_rsp_valid = 0;
    end else begin
      mem_rsp_valid = 0;
      if (outstanding) begin
        if (lat_cnt == 0) begin
          mem_rsp_valid = 1;
          mem_rsp_data  = fixed_en ? fixed_data
                                   : {$urandom, $urandom, $urandom, $urandom};
          rd_fire     = 1;
          rd_data     = mem_rsp_data;
          outstanding = 0;
        end else begin
          lat_cnt--;
        end
      end else if (spur_req || (spur_en && $urandom_range(0, 7) == 0)) begin
        // Stray data with no read in flight must be ignored by the DUT.
        mem_rsp_valid = 1;
        mem_rsp_data  = {$urandom, $urandom, $urandom, $urandom};
      end
      case (ready_mode)
        0:       mem_req_ready = 1'($urandom_range(0, 1));
        1:       mem_req_ready = 1;
        default: mem_req_ready = 0;
      endcase
      if (mem_req_valid && mem_req_ready && !outstanding) begin
        outstanding = 1;
        lat_cnt     = $urandom_range(lat_hi, lat_lo);
        n_reads++;
      end
    end
  end

  // ---------------- reference model + per-cycle compare ----------------
  typedef struct {
    logic [1:0]  thr;
    logic [19:0] addr;
    bit          bad;
  } ent_t;

  ent_t         mq[$];
  bit   [3:0]   m_pend = '0;
  bit           m_err = 0;
  bit           exp_flag = 0;
  logic [127:0] exp_data = '0;
  bit           prev_rsp = 0, pv = 0, pr = 0;
  logic [19:0]  pa = '0;
  logic [1:0]   rsp_log[$];

  always @(negedge clock) begin
    if (reset) begin
      check("rst_mem_req_valid", mem_req_valid, 0);
      check("rst_mem_req_addr", mem_req_addr, 0);
      check("rst_rsp_valid", rsp_valid_miss, 0);
      check("rst_rsp_data", rsp_data_miss, 0);
      check("rst_pending", pending_thr, 0);
      check("rst_err_dup", err_dup, 0);
      mq.delete();
      m_pend   = '0;
      m_err    = 0;
      exp_flag = 0;
      prev_rsp = 0;
      pv       = 0;
    end else begin
      if (exp_flag) check("rsp_after_mem_data", rsp_valid_miss, 1);
      check("pending_thr", pending_thr, m_pend);
      check("err_dup", err_dup, m_err);
      if (pv && !pr) begin
        check("mreq_hold_valid", mem_req_valid, 1);
        check("mreq_hold_addr", mem_req_addr, pa);
      end
      if (mem_req_valid) begin
        if (mq.size() == 0) check("mreq_with_empty_queue", mq.size(), 1);
        else begin
          check("mreq_head_good", mq[0].bad, 0);
          check("mreq_addr", mem_req_addr, mq[0].addr);
        end
      end
      if (rsp_valid_miss) begin
        check("rsp_one_cycle", prev_rsp, 0);
        if (mq.size() == 0) check("rsp_with_empty_queue", mq.size(), 1);
        else begin
          check("rsp_thread", rsp_thread_id, mq[0].thr);
          check("rsp_bus_error", rsp_bus_error, mq[0].bad);
          check("rsp_data", rsp_data_miss, mq[0].bad ? 128'd0 : exp_data);
          if (mq[0].bad) check("rsp_err_without_mem", exp_flag, 0);
          rsp_log.push_back(rsp_thread_id);
        end
      end
      // Advance the model to what the coming edge must produce.
      begin
        bit was_pend;
        was_pend = m_pend[req_thread_id_miss];
        if (rsp_valid_miss && mq.size() > 0) begin
          m_pend[mq[0].thr] = 0;
          void'(mq.pop_front());
        end
        if (req_valid_miss) begin
          if (was_pend) m_err = 1;
          else begin
            ent_t e;
            e.thr  = req_thread_id_miss;
            e.addr = req_addr_miss & ~20'hF;
            e.bad  = (req_addr_miss >= 20'h80000);
            mq.push_back(e);
            m_pend[req_thread_id_miss] = 1;
          end
        end
      end
      exp_flag = rd_fire;
      exp_data = rd_data;
      prev_rsp = rsp_valid_miss;
      pv = mem_req_valid;
      pr = mem_req_ready;
      pa = mem_req_addr;
    end
  end

  // ---------------- stimulus ----------------
  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  task automatic req(input logic [1:0] thr, input logic [19:0] addr);
    req_valid_miss     = 1;
    req_thread_id_miss = thr;
    req_addr_miss      = addr;
  endtask

  task automatic drain(input int max);
    int i = 0;
    req_valid_miss = 0;
    while (mq.size() != 0 && i < max) begin
      cyc();
      i++;
    end
    check("drain_empty", mq.size(), 0);
    cyc();
    cyc();
  endtask

  function automatic logic [19:0] rand_good();
    return 20'($urandom_range(0, 32'h7FFFF));
  endfunction

  initial begin
    int r0;
    int l0;
    reset = 1;
    req_valid_miss = 0;
    req_addr_miss = '0;
    req_thread_id_miss = '0;
    mem_req_ready = 0;
    mem_rsp_valid = 0;
    mem_rsp_data = '0;
    repeat (3) cyc();
    check("reset_rsp_valid", rsp_valid_miss, 0);
    check("reset_pending", pending_thr, 4'h0);
    reset = 0;
    cyc();

    // Single good line at minimum latency.
    ready_mode = 1; lat_lo = 0; lat_hi = 0;
    fixed_en = 1; fixed_data = 128'hA5A5A5A5A5A5A5A5A5A5A5A5A5A5A5A5;
    req(2'd1, 20'h01234);
    cyc();                                   // T+1
    req_valid_miss = 0;
    check("t1_pending_set", pending_thr, 4'b0010);
    check("t1_no_mreq_T1", mem_req_valid, 0);
    cyc();                                   // T+2
    check("t1_mreq_T2", mem_req_valid, 1);
    check("t1_mreq_addr", mem_req_addr, 20'h01230);
    cyc();                                   // T+3
    check("t1_no_rsp_T3", rsp_valid_miss, 0);
    cyc();                                   // T+4
    check("t1_rsp_T4", rsp_valid_miss, 1);
    check("t1_rsp_thr", rsp_thread_id, 2'd1);
    check("t1_rsp_data", rsp_data_miss, 128'hA5A5A5A5A5A5A5A5A5A5A5A5A5A5A5A5);
    cyc();
    check("t1_rsp_gone", rsp_valid_miss, 0);
    check("t1_pending_clear", pending_thr, 4'h0);
    fixed_en = 0;

    // Three threads back to back, served in order.
    ready_mode = 0; lat_lo = 0; lat_hi = 3;
    rsp_log.delete();
    r0 = n_reads;
    req(2'd0, rand_good()); cyc();
    req(2'd2, rand_good()); cyc();
    req(2'd3, rand_good()); cyc();
    drain(200);
    check("t2_reads", n_reads - r0, 3);
    check("t2_rsp_count", rsp_log.size(), 3);
    if (rsp_log.size() == 3) begin
      check("t2_order0", rsp_log[0], 2'd0);
      check("t2_order1", rsp_log[1], 2'd2);
      check("t2_order2", rsp_log[2], 2'd3);
    end

    // Bad address: error response at T+2, no memory read.
    r0 = n_reads;
    req(2'd2, 20'h90000);
    cyc();
    req_valid_miss = 0;
    check("t3_no_mreq_T1", mem_req_valid, 0);
    check("t3_no_rsp_T1", rsp_valid_miss, 0);
    cyc();
    check("t3_rsp_T2", rsp_valid_miss, 1);
    check("t3_bus_error", rsp_bus_error, 1);
    check("t3_data_zero", rsp_data_miss, 128'd0);
    check("t3_thr", rsp_thread_id, 2'd2);
    check("t3_no_mreq_T2", mem_req_valid, 0);
    cyc();
    check("t3_pending_clear", pending_thr, 4'h0);
    check("t3_reads", n_reads - r0, 0);

    // Duplicate request from thread 1 before its response.
    ready_mode = 2;
    r0 = n_reads;
    l0 = rsp_log.size();
    req(2'd1, 20'h00400); cyc();
    req(2'd1, 20'h00800); cyc();
    req_valid_miss = 0;
    check("t4_err_dup", err_dup, 1);
    ready_mode = 1;
    drain(100);
    check("t4_reads", n_reads - r0, 1);
    check("t4_rsp_count", rsp_log.size() - l0, 1);
    check("t4_err_dup_sticky", err_dup, 1);

    // Memory stalls for 5 cycles; a request queued meanwhile follows.
    ready_mode = 2;
    l0 = rsp_log.size();
    req(2'd0, 20'h12345); cyc();
    req_valid_miss = 0; cyc();
    for (int i = 0; i < 5; i++) begin
      check("t5_stall_valid", mem_req_valid, 1);
      check("t5_stall_addr", mem_req_addr, 20'h12340);
      if (i == 1) req(2'd3, 20'h45678);
      else req_valid_miss = 0;
      cyc();
    end
    req_valid_miss = 0;
    ready_mode = 1;
    drain(100);
    check("t5_rsp_count", rsp_log.size() - l0, 2);
    if (rsp_log.size() - l0 == 2) begin
      check("t5_order0", rsp_log[l0], 2'd0);
      check("t5_order1", rsp_log[l0 + 1], 2'd3);
    end

    // Reset while a read is in flight; late memory data must be ignored.
    lat_lo = 20; lat_hi = 20;
    l0 = rsp_log.size();
    req(2'd2, 20'h00AB0); cyc();
    req_valid_miss = 0; cyc(); cyc();
    reset = 1;
    #1;
    check("t6_rst_mreq_valid", mem_req_valid, 0);
    check("t6_rst_rsp_valid", rsp_valid_miss, 0);
    check("t6_rst_pending", pending_thr, 4'h0);
    check("t6_rst_err_dup", err_dup, 0);
    check("t6_rst_rsp_thr", rsp_thread_id, 2'd0);
    cyc(); cyc();
    reset = 0;
    spur_req = 1;
    cyc();
    spur_req = 0;
    repeat (4) begin
      check("t6_no_rsp", rsp_valid_miss, 0);
      check("t6_no_mreq", mem_req_valid, 0);
      cyc();
    end
    check("t6_rsp_count", rsp_log.size() - l0, 0);
    lat_lo = 0; lat_hi = 3;

    // Randomized traffic including limit-boundary addresses.
    ready_mode = 0; spur_en = 1;
    for (int c = 0; c < 1500; c++) begin
      if ($urandom_range(0, 2) == 0) begin
        int k;
        logic [19:0] a;
        k = $urandom_range(0, 9);
        case (k)
          0:       a = 20'h7FFFF;
          1:       a = 20'h80000;
          2, 3:    a = 20'h80000 | rand_good();
          default: a = rand_good();
        endcase
        req(2'($urandom_range(0, 3)), a);
      end else begin
        req_valid_miss = 0;
      end
      cyc();
    end
    spur_en = 0;
    drain(400);
    check("final_pending", pending_thr, 4'h0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
